// File: rtl/tile_raster.sv
// Tile rasteriser: walks a 2^TILE_W_LOG2 x 2^TILE_H_LOG2 tile in row-major order with three
// incremental edge functions and emits one write per covered pixel.
// Optional covered-pixel counter enabled by macro TILE_RASTER_COVER_COUNT_EN.
module tile_raster #(
   parameter int unsigned TILE_W_LOG2 = 5,
   parameter int unsigned TILE_H_LOG2 = 5,
   parameter int unsigned A_W         = 19,
   parameter int unsigned B_W         = 24,
   parameter int unsigned W_W         = 32,
   parameter int unsigned COLOR_W     = 16
) (
   input  logic                                 clk,
   input  logic                                 resetn,

   input  logic                                 start_valid,
   output logic                                 start_ready,
   input  logic signed [A_W-1:0]                A01_in,
   input  logic signed [A_W-1:0]                A12_in,
   input  logic signed [A_W-1:0]                A20_in,
   input  logic signed [B_W-1:0]                B01_in,
   input  logic signed [B_W-1:0]                B12_in,
   input  logic signed [B_W-1:0]                B20_in,
   input  logic signed [W_W-1:0]                w0_in,
   input  logic signed [W_W-1:0]                w1_in,
   input  logic signed [W_W-1:0]                w2_in,
   input  logic        [COLOR_W-1:0]            color_in,

   output logic                                 pix_valid,
   input  logic                                 pix_ready,
   output logic [TILE_W_LOG2+TILE_H_LOG2-1:0]   pix_addr,
   output logic [COLOR_W-1:0]                   pix_data,
`ifdef TILE_RASTER_COVER_COUNT_EN
   output logic [TILE_W_LOG2+TILE_H_LOG2:0]     covered_count,
`endif
   output logic                                 busy,
   output logic                                 done
);

   localparam int unsigned IDX_W = TILE_W_LOG2 + TILE_H_LOG2;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic signed [W_W-1:0]  w0_q, w0_d;
   logic signed [W_W-1:0]  w1_q, w1_d;
   logic signed [W_W-1:0]  w2_q, w2_d;
   logic                   done_q, done_d;

   logic signed [A_W-1:0]  a01_q, a12_q, a20_q;
   logic signed [B_W-1:0]  b01_q, b12_q, b20_q;
   logic [COLOR_W-1:0]     color_q;

   logic                   accept;
   logic                   advance;
   logic                   covered;
   logic                   row_end;
   logic                   last_pix;
   logic signed [W_W-1:0]  step0, step1, step2;

   // A pixel is inside when every edge function is non-negative.
   assign covered  = ~(w0_q[W_W-1] | w1_q[W_W-1] | w2_q[W_W-1]);
   assign row_end  = &idx_q[TILE_W_LOG2-1:0];
   assign last_pix = &idx_q;

   // Row steps already include the rewind from the last column back to column 0.
   assign step0 = row_end ? W_W'(b12_q) : W_W'(a12_q);
   assign step1 = row_end ? W_W'(b20_q) : W_W'(a20_q);
   assign step2 = row_end ? W_W'(b01_q) : W_W'(a01_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      done_d  = 1'b0;
      accept  = 1'b0;
      advance = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_valid) begin
               accept  = 1'b1;
               state_d = StRun;
               idx_d   = '0;
               w0_d    = w0_in;
               w1_d    = w1_in;
               w2_d    = w2_in;
            end
         end
         StRun: begin
            if (!covered || pix_ready) begin
               advance = 1'b1;
               idx_d   = idx_q + IDX_W'(1);
               w0_d    = w0_q + step0;
               w1_d    = w1_q + step1;
               w2_d    = w2_q + step2;
               if (last_pix) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         idx_q   <= '0;
         w0_q    <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a01_q   <= '0;
         a12_q   <= '0;
         a20_q   <= '0;
         b01_q   <= '0;
         b12_q   <= '0;
         b20_q   <= '0;
         color_q <= '0;
      end else if (accept) begin
         a01_q   <= A01_in;
         a12_q   <= A12_in;
         a20_q   <= A20_in;
         b01_q   <= B01_in;
         b12_q   <= B12_in;
         b20_q   <= B20_in;
         color_q <= color_in;
      end
   end

   assign start_ready = (state_q == StIdle);
   assign busy        = (state_q == StRun);
   assign pix_valid   = busy && covered;
   assign pix_addr    = idx_q;
   assign pix_data    = color_q;
   assign done        = done_q;

`ifdef TILE_RASTER_COVER_COUNT_EN
   logic [IDX_W:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (pix_valid && pix_ready) begin
         cnt_q <= cnt_q + (IDX_W+1)'(1);
      end
   end

   assign covered_count = cnt_q;
`endif

endmodule
